// File: rtl/layer_linebuf_sequencer_pkg.sv
// Shared definitions for the layer line-buffer sequencer: FSM state
// encodings and default widths for the pixel index and line counter.
package layer_linebuf_sequencer_pkg;

    localparam int LBSEQ_IDX_W  = 10;
    localparam int LBSEQ_LINE_W = 9;

    typedef enum logic [1:0] {
        LBSEQ_IDLE      = 2'b00,
        LBSEQ_RENDER    = 2'b01,
        LBSEQ_WAIT_SWAP = 2'b10
    } lbseq_state_e;

endpackage

// File: rtl/layer_linebuf_sequencer_linebuf_rd_counter.sv
// Composer-side read sequencer. It latches the line width when a read starts,
// steps the read index from 0 to width-1 and then parks it at 0. The valid
// flag lags the index by one cycle to line up with the line-buffer RAM
// read latency.
module linebuf_rd_counter
    import layer_linebuf_sequencer_pkg::*;
#(
    parameter int IDX_W = LBSEQ_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] width,
    output logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid
);

    logic [IDX_W-1:0] width_r;
    logic [IDX_W-1:0] idx_r;
    logic             reading_r;
    logic             valid_r;
    logic             last_s;

    // The final pixel of the line is the one at index width-1.
    assign last_s = (idx_r == (width_r - IDX_W'(1)));

    // Width latch, index counter and read-active flag. A start in mid-read
    // restarts the index at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_r   <= '0;
            idx_r     <= '0;
            reading_r <= 1'b0;
        end else if (start) begin
            width_r   <= width;
            idx_r     <= '0;
            reading_r <= 1'b1;
        end else if (reading_r) begin
            if (last_s) begin
                idx_r     <= '0;
                reading_r <= 1'b0;
            end else begin
                idx_r     <= idx_r + IDX_W'(1);
            end
        end
    end

    // Read data becomes valid one cycle after its index is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= reading_r;
        end
    end

    assign rd_idx   = idx_r;
    assign rd_valid = valid_r;

endmodule

// File: rtl/layer_linebuf_sequencer.sv
// Line-buffer sequencer for one display layer. It owns the double-buffer
// select, kicks the renderer for each new line, flags a missed render
// deadline as an underrun, and drives the composer read index stream for
// the line currently on display.
module layer_linebuf_sequencer
    import layer_linebuf_sequencer_pkg::*;
#(
    parameter int IDX_W  = LBSEQ_IDX_W,
    parameter int LINE_W = LBSEQ_LINE_W
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [IDX_W-1:0]  line_width,
    output logic              render_start,
    output logic [LINE_W-1:0] render_line,
    input  logic              render_done,
    output logic              active_render_buffer,
    output logic [IDX_W-1:0]  composer_rd_idx,
    output logic              composer_rd_valid,
    output logic              underrun,
    output logic              busy
);

    lbseq_state_e      state_r;
    lbseq_state_e      state_next_s;
    logic              render_start_r;
    logic              render_start_s;
    logic [LINE_W-1:0] render_line_r;
    logic [LINE_W-1:0] render_line_next_s;
    logic              active_buf_r;
    logic              swap_s;
    logic              underrun_r;
    logic              underrun_s;
    logic              busy_r;
    logic              rd_start_s;

    // Composer reads follow every line_start once the first frame has begun;
    // a frame_start in the same cycle counts as having begun.
    assign rd_start_s = line_start & ((state_r != LBSEQ_IDLE) | frame_start);

    // Next-state and per-cycle control decode. frame_start has priority over
    // everything; a line_start while still rendering forces the swap and
    // reports underrun unless render_done lands in that same cycle.
    always_comb begin
        state_next_s       = state_r;
        render_start_s     = 1'b0;
        render_line_next_s = render_line_r;
        swap_s             = 1'b0;
        underrun_s         = 1'b0;
        case (state_r)
            LBSEQ_IDLE: begin
                if (frame_start) begin
                    state_next_s       = LBSEQ_RENDER;
                    render_start_s     = 1'b1;
                    render_line_next_s = '0;
                end else begin
                    state_next_s       = LBSEQ_IDLE;
                end
            end
            LBSEQ_RENDER: begin
                if (frame_start) begin
                    state_next_s       = LBSEQ_RENDER;
                    render_start_s     = 1'b1;
                    render_line_next_s = '0;
                end else if (line_start) begin
                    state_next_s       = LBSEQ_RENDER;
                    render_start_s     = 1'b1;
                    render_line_next_s = render_line_r + LINE_W'(1);
                    swap_s             = 1'b1;
                    underrun_s         = ~render_done;
                end else if (render_done) begin
                    state_next_s       = LBSEQ_WAIT_SWAP;
                end else begin
                    state_next_s       = LBSEQ_RENDER;
                end
            end
            LBSEQ_WAIT_SWAP: begin
                if (frame_start) begin
                    state_next_s       = LBSEQ_RENDER;
                    render_start_s     = 1'b1;
                    render_line_next_s = '0;
                end else if (line_start) begin
                    state_next_s       = LBSEQ_RENDER;
                    render_start_s     = 1'b1;
                    render_line_next_s = render_line_r + LINE_W'(1);
                    swap_s             = 1'b1;
                end else begin
                    state_next_s       = LBSEQ_WAIT_SWAP;
                end
            end
            default: begin
                state_next_s = LBSEQ_IDLE;
            end
        endcase
    end

    // State register and registered outputs; busy is registered from the
    // next state so it tracks the RENDER state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= LBSEQ_IDLE;
            render_start_r <= 1'b0;
            render_line_r  <= '0;
            active_buf_r   <= 1'b0;
            underrun_r     <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            render_start_r <= render_start_s;
            render_line_r  <= render_line_next_s;
            active_buf_r   <= active_buf_r ^ swap_s;
            underrun_r     <= underrun_s;
            busy_r         <= (state_next_s == LBSEQ_RENDER);
        end
    end

    linebuf_rd_counter #(
        .IDX_W (IDX_W)
    ) u_rd_counter (
        .clk      (clk),
        .rst      (rst),
        .start    (rd_start_s),
        .width    (line_width),
        .rd_idx   (composer_rd_idx),
        .rd_valid (composer_rd_valid)
    );

    assign render_start         = render_start_r;
    assign render_line          = render_line_r;
    assign active_render_buffer = active_buf_r;
    assign underrun             = underrun_r;
    assign busy                 = busy_r;

endmodule

// File: tb/tb_layer_linebuf_sequencer.sv
// Directed self-checking bench for layer_linebuf_sequencer.
module tb_layer_linebuf_sequencer;

    logic       rst;
    logic       clk;
    logic       frame_start;
    logic       line_start;
    logic [9:0] line_width;
    logic       render_start;
    logic [8:0] render_line;
    logic       render_done;
    logic       active_render_buffer;
    logic [9:0] composer_rd_idx;
    logic       composer_rd_valid;
    logic       underrun;
    logic       busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    layer_linebuf_sequencer #(.IDX_W(10), .LINE_W(9)) dut (
        .rst                  (rst),
        .clk                  (clk),
        .frame_start          (frame_start),
        .line_start           (line_start),
        .line_width           (line_width),
        .render_start         (render_start),
        .render_line          (render_line),
        .render_done          (render_done),
        .active_render_buffer (active_render_buffer),
        .composer_rd_idx      (composer_rd_idx),
        .composer_rd_valid    (composer_rd_valid),
        .underrun             (underrun),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_cnt++; if (render_start !== 1'b0) $display("FAIL reset_rs got %0b want 0", render_start); else pass_cnt++;
        chk_cnt++; if (render_line !== 9'd0) $display("FAIL reset_line got %0d want 0", render_line); else pass_cnt++;
        chk_cnt++; if (active_render_buffer !== 1'b0) $display("FAIL reset_buf got %0b want 0", active_render_buffer); else pass_cnt++;
        chk_cnt++; if (composer_rd_idx !== 10'd0) $display("FAIL reset_idx got %0d want 0", composer_rd_idx); else pass_cnt++;
        chk_cnt++; if (composer_rd_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", composer_rd_valid); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %0b want 0", underrun); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_idle_ignore();
        for (int n = 0; n < 3; n++) begin
            line_width = 10'd16;
            line_start = 1'b1;
            tick();
            line_start = 1'b0;
            for (int c = 0; c < 3; c++) begin
                chk_cnt++; if (render_start !== 1'b0) $display("FAIL idle_rs got %0b want 0", render_start); else pass_cnt++;
                chk_cnt++; if (active_render_buffer !== 1'b0) $display("FAIL idle_buf got %0b want 0", active_render_buffer); else pass_cnt++;
                chk_cnt++; if (composer_rd_valid !== 1'b0 || composer_rd_idx !== 10'd0)
                    $display("FAIL idle_read got idx=%0d valid=%0b want idx=0 valid=0", composer_rd_idx, composer_rd_valid); else pass_cnt++;
                tick();
            end
        end
    endtask

    task automatic test_basic_line();
        int bad;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk_cnt++; if (render_start !== 1'b1) $display("FAIL frame_rs got %0b want 1", render_start); else pass_cnt++;
        chk_cnt++; if (render_line !== 9'd0) $display("FAIL frame_line got %0d want 0", render_line); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL frame_busy got %0b want 1", busy); else pass_cnt++;
        tick();
        chk_cnt++; if (render_start !== 1'b0) $display("FAIL frame_rs_once got %0b want 0", render_start); else pass_cnt++;
        for (int c = 0; c < 48; c++) tick();
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL wait_busy got %0b want 0", busy); else pass_cnt++;
        line_width = 10'd640;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk_cnt++; if (active_render_buffer !== 1'b1) $display("FAIL swap1_buf got %0b want 1", active_render_buffer); else pass_cnt++;
        chk_cnt++; if (render_start !== 1'b1) $display("FAIL swap1_rs got %0b want 1", render_start); else pass_cnt++;
        chk_cnt++; if (render_line !== 9'd1) $display("FAIL swap1_line got %0d want 1", render_line); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL swap1_underrun got %0b want 0", underrun); else pass_cnt++;
        chk_cnt++; if (composer_rd_idx !== 10'd0 || composer_rd_valid !== 1'b0)
            $display("FAIL swap1_rd0 got idx=%0d valid=%0b want idx=0 valid=0", composer_rd_idx, composer_rd_valid); else pass_cnt++;
        bad = 0;
        for (int k = 1; k <= 640; k++) begin
            tick();
            if (k == 1) begin
                chk_cnt++; if (render_start !== 1'b0) $display("FAIL swap1_rs_once got %0b want 0", render_start); else pass_cnt++;
            end
            chk_cnt++;
            if (composer_rd_idx !== ((k < 640) ? k[9:0] : 10'd0) || composer_rd_valid !== 1'b1) begin
                bad++;
                if (bad <= 5) $display("FAIL sweep640 k=%0d got idx=%0d valid=%0b want idx=%0d valid=1",
                                       k, composer_rd_idx, composer_rd_valid, (k < 640) ? k : 0);
            end else pass_cnt++;
        end
        tick();
        chk_cnt++; if (composer_rd_valid !== 1'b0 || composer_rd_idx !== 10'd0)
            $display("FAIL sweep640_end got idx=%0d valid=%0b want idx=0 valid=0", composer_rd_idx, composer_rd_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL render2_busy got %0b want 1", busy); else pass_cnt++;
    endtask

    task automatic test_underrun();
        line_width = 10'd8;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk_cnt++; if (underrun !== 1'b1) $display("FAIL ur_pulse got %0b want 1", underrun); else pass_cnt++;
        chk_cnt++; if (active_render_buffer !== 1'b0) $display("FAIL ur_buf got %0b want 0", active_render_buffer); else pass_cnt++;
        chk_cnt++; if (render_line !== 9'd2) $display("FAIL ur_line got %0d want 2", render_line); else pass_cnt++;
        chk_cnt++; if (render_start !== 1'b1) $display("FAIL ur_rs got %0b want 1", render_start); else pass_cnt++;
        tick();
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL ur_once got %0b want 0", underrun); else pass_cnt++;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_done_with_line_start();
        logic [9:0] exp_idx [0:4];
        logic       exp_val [0:4];
        exp_idx[0] = 10'd1; exp_idx[1] = 10'd2; exp_idx[2] = 10'd3; exp_idx[3] = 10'd0; exp_idx[4] = 10'd0;
        exp_val[0] = 1'b1;  exp_val[1] = 1'b1;  exp_val[2] = 1'b1;  exp_val[3] = 1'b1;  exp_val[4] = 1'b0;
        render_done = 1'b1;
        line_start  = 1'b1;
        line_width  = 10'd4;
        tick();
        render_done = 1'b0;
        line_start  = 1'b0;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL coinc_underrun got %0b want 0", underrun); else pass_cnt++;
        chk_cnt++; if (active_render_buffer !== 1'b1) $display("FAIL coinc_buf got %0b want 1", active_render_buffer); else pass_cnt++;
        chk_cnt++; if (render_line !== 9'd3) $display("FAIL coinc_line got %0d want 3", render_line); else pass_cnt++;
        chk_cnt++; if (render_start !== 1'b1) $display("FAIL coinc_rs got %0b want 1", render_start); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_cnt++; if (composer_rd_idx !== exp_idx[k] || composer_rd_valid !== exp_val[k])
                $display("FAIL sweep4 step=%0d got idx=%0d valid=%0b want idx=%0d valid=%0b",
                         k, composer_rd_idx, composer_rd_valid, exp_idx[k], exp_val[k]); else pass_cnt++;
        end
    endtask

    task automatic test_frame_restart();
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL fr_wait_busy got %0b want 0", busy); else pass_cnt++;
        frame_start = 1'b1;
        line_start  = 1'b1;
        line_width  = 10'd5;
        tick();
        frame_start = 1'b0;
        line_start  = 1'b0;
        chk_cnt++; if (render_line !== 9'd0) $display("FAIL fr_line got %0d want 0", render_line); else pass_cnt++;
        chk_cnt++; if (active_render_buffer !== 1'b1) $display("FAIL fr_buf got %0b want 1", active_render_buffer); else pass_cnt++;
        chk_cnt++; if (render_start !== 1'b1) $display("FAIL fr_rs got %0b want 1", render_start); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL fr_underrun got %0b want 0", underrun); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL fr_busy got %0b want 1", busy); else pass_cnt++;
        chk_cnt++; if (composer_rd_idx !== 10'd0 || composer_rd_valid !== 1'b0)
            $display("FAIL fr_rd0 got idx=%0d valid=%0b want idx=0 valid=0", composer_rd_idx, composer_rd_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (composer_rd_idx !== 10'd1 || composer_rd_valid !== 1'b1)
            $display("FAIL fr_rd1 got idx=%0d valid=%0b want idx=1 valid=1", composer_rd_idx, composer_rd_valid); else pass_cnt++;
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_wrap_and_reset();
        for (int n = 0; n < 511; n++) begin
            render_done = 1'b1;
            tick();
            render_done = 1'b0;
            line_width = 10'd2;
            line_start = 1'b1;
            tick();
            line_start = 1'b0;
        end
        chk_cnt++; if (render_line !== 9'd511) $display("FAIL wrap_pre_line got %0d want 511", render_line); else pass_cnt++;
        chk_cnt++; if (active_render_buffer !== 1'b0) $display("FAIL wrap_pre_buf got %0b want 0", active_render_buffer); else pass_cnt++;
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        line_width = 10'd100;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk_cnt++; if (render_line !== 9'd0) $display("FAIL wrap_line got %0d want 0", render_line); else pass_cnt++;
        chk_cnt++; if (active_render_buffer !== 1'b1) $display("FAIL wrap_buf got %0b want 1", active_render_buffer); else pass_cnt++;
        chk_cnt++; if (render_start !== 1'b1) $display("FAIL wrap_rs got %0b want 1", render_start); else pass_cnt++;
        tick();
        tick();
        tick();
        chk_cnt++; if (composer_rd_idx !== 10'd3 || composer_rd_valid !== 1'b1)
            $display("FAIL midread got idx=%0d valid=%0b want idx=3 valid=1", composer_rd_idx, composer_rd_valid); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++; if (composer_rd_idx !== 10'd0) $display("FAIL rst_idx got %0d want 0", composer_rd_idx); else pass_cnt++;
        chk_cnt++; if (composer_rd_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", composer_rd_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else pass_cnt++;
        chk_cnt++; if (active_render_buffer !== 1'b0) $display("FAIL rst_buf got %0b want 0", active_render_buffer); else pass_cnt++;
        tick();
        chk_cnt++; if (composer_rd_valid !== 1'b0 || composer_rd_idx !== 10'd0)
            $display("FAIL rst_abort got idx=%0d valid=%0b want idx=0 valid=0", composer_rd_idx, composer_rd_valid); else pass_cnt++;
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        line_width  = 10'd0;
        render_done = 1'b0;
        test_reset();
        test_idle_ignore();
        test_basic_line();
        test_underrun();
        test_done_with_line_start();
        test_frame_restart();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
